// File: rtl/ag32gbd_frame_scanner_if.sv
// Control, sampler and frame-BRAM signals of the frame scanner; master is the scanner's view.
// AG32GBD_SCAN_TEST_PATTERN_EN adds the TestMode control input.
interface ag32gbd_frame_scanner_if;
   logic        FrameStart;
   logic        FrameAbort;
   logic        Busy;
   logic        FrameDone;
   logic        TimeoutErr;
   logic        SampleStart;
   logic [6:0]  PixelX;
   logic [6:0]  PixelY;
   logic        SampleDone;
   logic [1:0]  SampledValue;
   logic        WrEn;
   logic [11:0] WrAddr;
   logic [7:0]  WrData;
`ifdef AG32GBD_SCAN_TEST_PATTERN_EN
   logic        TestMode;

   modport master (
      input  FrameStart, FrameAbort, SampleDone, SampledValue, TestMode,
      output Busy, FrameDone, TimeoutErr, SampleStart, PixelX, PixelY,
             WrEn, WrAddr, WrData
   );
   modport slave (
      output FrameStart, FrameAbort, SampleDone, SampledValue, TestMode,
      input  Busy, FrameDone, TimeoutErr, SampleStart, PixelX, PixelY,
             WrEn, WrAddr, WrData
   );
`else
   modport master (
      input  FrameStart, FrameAbort, SampleDone, SampledValue,
      output Busy, FrameDone, TimeoutErr, SampleStart, PixelX, PixelY,
             WrEn, WrAddr, WrData
   );
   modport slave (
      output FrameStart, FrameAbort, SampleDone, SampledValue,
      input  Busy, FrameDone, TimeoutErr, SampleStart, PixelX, PixelY,
             WrEn, WrAddr, WrData
   );
`endif
endinterface

// File: rtl/ag32gbd_frame_scanner.sv
// Raster-order frame sequencer: drives the pixel sampler, packs 4 pixels per byte into BRAM.
// Optional AG32GBD_SCAN_TEST_PATTERN_EN replaces sampling with a synthetic pattern.
module ag32gbd_frame_scanner #(
   parameter int WIDTH      = 128,
   parameter int HEIGHT     = 112,
   parameter int START_HOLD = 3,
   parameter int TIMEOUT    = 1023
) (
   input logic                     sys_clock,
   input logic                     sys_resetn,
   ag32gbd_frame_scanner_if.master bus
);

   localparam int CNT_MAX = (TIMEOUT > START_HOLD) ? TIMEOUT : START_HOLD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [6:0]       X_LAST    = 7'(WIDTH - 1);
   localparam logic [6:0]       Y_LAST    = 7'(HEIGHT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(START_HOLD - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TEST_CAP  = CNT_W'(1);
   localparam logic [13:0]      WIDTH_L   = 14'(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_DONE,
      S_WAIT_LOW,
      S_ADVANCE,
      S_DONE
   } state_t;

   state_t state, next_state;

   logic             start_q, start_prev, done_prev;
   logic [6:0]       px, py;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       byte_sr;
   logic             timeout_err;
   logic             test_q;
   logic [1:0]       pattern;
   logic [13:0]      lin;

   logic       start_edge, done_edge, last_px, last_pixel, abort;
   logic       accept, cnt_clr, shift_en, set_timeout, advance;
   logic [1:0] shift_val;

   assign start_edge = start_q & ~start_prev;
   assign done_edge  = bus.SampleDone & ~done_prev;
   assign last_px    = (px == X_LAST);
   assign last_pixel = last_px && (py == Y_LAST);
   assign abort      = (state != S_IDLE) && bus.FrameAbort;
   assign lin        = 14'(py) * WIDTH_L + 14'(px);

`ifdef AG32GBD_SCAN_TEST_PATTERN_EN
   // Test mode is latched at accept so the whole frame is either sampled or synthetic.
   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn)  test_q <= 1'b0;
      else if (accept)  test_q <= bus.TestMode;
   end
   assign pattern = px[4:3] ^ py[4:3];
`else
   assign test_q  = 1'b0;
   assign pattern = 2'b00;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) state <= S_IDLE;
      else             state <= next_state;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      next_state      = state;
      accept          = 1'b0;
      cnt_clr         = 1'b0;
      shift_en        = 1'b0;
      shift_val       = 2'b00;
      set_timeout     = 1'b0;
      advance         = 1'b0;
      bus.SampleStart = 1'b0;
      bus.Busy        = 1'b0;
      bus.FrameDone   = 1'b0;
      bus.WrEn        = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (start_edge && !bus.FrameAbort) begin
               accept     = 1'b1;
               cnt_clr    = 1'b1;
               next_state = S_START;
            end
         end
         S_START: begin
            bus.Busy        = 1'b1;
            bus.SampleStart = !test_q;
            if (test_q) begin
               if (cnt == TEST_CAP) begin
                  shift_en   = 1'b1;
                  shift_val  = pattern;
                  next_state = S_ADVANCE;
               end
            end else if (cnt == HOLD_LAST) begin
               cnt_clr    = 1'b1;
               next_state = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            bus.Busy = 1'b1;
            if (done_edge) begin
               shift_en   = 1'b1;
               shift_val  = bus.SampledValue;
               next_state = S_WAIT_LOW;
            end else if (cnt == TO_LAST) begin
               shift_en    = 1'b1;
               set_timeout = 1'b1;
               next_state  = S_ADVANCE;
            end
         end
         S_WAIT_LOW: begin
            bus.Busy = 1'b1;
            if (!bus.SampleDone) next_state = S_ADVANCE;
         end
         S_ADVANCE: begin
            bus.Busy   = 1'b1;
            bus.WrEn   = (px[1:0] == 2'b11);
            advance    = 1'b1;
            cnt_clr    = 1'b1;
            next_state = last_pixel ? S_DONE : S_START;
         end
         S_DONE: begin
            bus.FrameDone = 1'b1;
            next_state    = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase

      // Abort overrides all progress; the partial byte is dropped in the datapath.
      if (abort) begin
         next_state  = S_IDLE;
         shift_en    = 1'b0;
         set_timeout = 1'b0;
         advance     = 1'b0;
      end
   end

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         start_q     <= 1'b0;
         start_prev  <= 1'b0;
         done_prev   <= 1'b0;
         cnt         <= '0;
         px          <= '0;
         py          <= '0;
         byte_sr     <= '0;
         timeout_err <= 1'b0;
      end else begin
         start_q    <= bus.FrameStart;
         start_prev <= start_q;
         done_prev  <= bus.SampleDone;

         if (cnt_clr)
            cnt <= '0;
         else if (state == S_START || state == S_WAIT_DONE)
            cnt <= cnt + CNT_W'(1);

         if (accept) begin
            px          <= '0;
            py          <= '0;
            byte_sr     <= '0;
            timeout_err <= 1'b0;
         end else begin
            if (abort)         byte_sr <= '0;
            else if (shift_en) byte_sr <= {byte_sr[5:0], shift_val};

            if (set_timeout) timeout_err <= 1'b1;

            if (advance) begin
               if (last_px) begin
                  px <= '0;
                  py <= py + 7'd1;
               end else begin
                  px <= px + 7'd1;
               end
            end
         end
      end
   end

   assign bus.PixelX     = px;
   assign bus.PixelY     = py;
   assign bus.WrAddr     = lin[13:2];
   assign bus.WrData     = byte_sr;
   assign bus.TimeoutErr = timeout_err;

endmodule

// File: tb/tb_ag32gbd_frame_scanner.sv
// Directed bench for ag32gbd_frame_scanner on a reduced 16x4 window with a behavioural sampler.
// Build with AG32GBD_SCAN_TEST_PATTERN_EN to add the test-pattern frame.
module tb_ag32gbd_frame_scanner;

   localparam int WIDTH      = 16;
   localparam int HEIGHT     = 4;
   localparam int START_HOLD = 3;
   localparam int TIMEOUT    = 40;
   localparam int DELAY      = 20;
   localparam int STRETCH    = 7;
   localparam int NBYTES     = WIDTH * HEIGHT / 4;
   localparam int NPIX       = WIDTH * HEIGHT;
   localparam int BUDGET     = 5000;

   logic sys_clock  = 1'b0;
   logic sys_resetn = 1'b0;

   ag32gbd_frame_scanner_if bus ();

   ag32gbd_frame_scanner #(
      .WIDTH      (WIDTH),
      .HEIGHT     (HEIGHT),
      .START_HOLD (START_HOLD),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .sys_clock  (sys_clock),
      .sys_resetn (sys_resetn),
      .bus        (bus)
   );

   always #5 sys_clock = ~sys_clock;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sampler model: mode 0 returns 2'b11, mode 1 returns x[1:0], mode 2 is mode 0 but mute at (5,0).
   int samp_mode = 0;

   initial begin : sampler
      logic [6:0] x, y;
      bus.SampleDone   = 1'b0;
      bus.SampledValue = 2'b00;
      forever begin
         do @(negedge sys_clock); while (bus.SampleStart !== 1'b1);
         x = bus.PixelX;
         y = bus.PixelY;
         if (!(samp_mode == 2 && x == 7'd5 && y == 7'd0)) begin
            repeat (DELAY) @(negedge sys_clock);
            bus.SampledValue = (samp_mode == 1) ? x[1:0] : 2'b11;
            bus.SampleDone   = 1'b1;
            repeat (STRETCH) @(negedge sys_clock);
            bus.SampleDone   = 1'b0;
         end
         while (bus.SampleStart === 1'b1) @(negedge sys_clock);
      end
   end

   // Passive monitor, sampled on the falling edge.
   int          cyc = 0;
   int          n_wr = 0, n_done = 0, n_runs = 0, n_bad_runs = 0, ss_total = 0, ss_run = 0;
   int          last_wr_cyc = 0, done_cyc = 0, ss_to_cyc = 0, te_rise_cyc = 0;
   logic        te_prev = 1'b0;
   logic [11:0] wr_addr [256];
   logic [7:0]  wr_data [256];

   always @(negedge sys_clock) begin
      cyc++;
      if (bus.WrEn === 1'b1) begin
         if (n_wr < 256) begin
            wr_addr[n_wr] = bus.WrAddr;
            wr_data[n_wr] = bus.WrData;
         end
         n_wr++;
         last_wr_cyc = cyc;
      end
      if (bus.FrameDone === 1'b1) begin
         n_done++;
         done_cyc = cyc;
      end
      if (bus.SampleStart === 1'b1) begin
         ss_run++;
         ss_total++;
         if (bus.PixelX == 7'd5 && bus.PixelY == 7'd0) ss_to_cyc = cyc;
      end else if (ss_run != 0) begin
         n_runs++;
         if (ss_run != START_HOLD) n_bad_runs++;
         ss_run = 0;
      end
      if (bus.TimeoutErr === 1'b1 && !te_prev) te_rise_cyc = cyc;
      te_prev = bus.TimeoutErr;
   end

   task automatic tick();
      @(negedge sys_clock);
      #1;
   endtask

   task automatic pulse_start();
      bus.FrameStart = 1'b1;
      tick();
      tick();
      bus.FrameStart = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int done_base);
      int t = 0;
      while (n_done == done_base && t < BUDGET) begin
         tick();
         t++;
      end
      check({tag, "_done_in_time"}, int'(t < BUDGET), 1);
   endtask

   task automatic check_bytes(input string tag, input int base, input int exp_data, input int exp_b1);
      for (int i = 0; i < NBYTES; i++) begin
         check($sformatf("%s_addr%0d", tag, i), int'(wr_addr[base + i]), i);
         check($sformatf("%s_data%0d", tag, i), int'(wr_data[base + i]), (i == 1) ? exp_b1 : exp_data);
      end
   endtask

   int wb, db, rb, bb, sb, t;

   initial begin
      bus.FrameStart = 1'b0;
      bus.FrameAbort = 1'b0;
`ifdef AG32GBD_SCAN_TEST_PATTERN_EN
      bus.TestMode   = 1'b0;
`endif
      #1;
      check("rst_ctrl", int'({bus.SampleStart, bus.Busy, bus.FrameDone, bus.TimeoutErr, bus.WrEn}), 0);
      check("rst_pos", int'({bus.PixelX, bus.PixelY, bus.WrAddr}), 0);
      check("rst_wdata", int'(bus.WrData), 0);
      repeat (3) tick();
      sys_resetn = 1'b1;
      repeat (3) tick();

      // Frame 1: constant 2'b11 -> every byte 8'hFF, ascending addresses.
      samp_mode = 0;
      wb = n_wr; db = n_done; rb = n_runs; bb = n_bad_runs;
      pulse_start();
      check("f1_busy", int'(bus.Busy), 1);
      wait_done("f1", db);
      check("f1_busy_low", int'(bus.Busy), 0);
      check("f1_writes", n_wr - wb, NBYTES);
      check("f1_done_gap", done_cyc - last_wr_cyc, 1);
      check("f1_ss_runs", n_runs - rb, NPIX);
      check("f1_ss_bad_runs", n_bad_runs - bb, 0);
      check("f1_timeout_err", int'(bus.TimeoutErr), 0);
      check_bytes("f1", wb, 'hFF, 'hFF);

      // Frame 2: value x[1:0] -> 8'h1B; second FrameStart mid-frame is ignored.
      repeat (5) tick();
      samp_mode = 1;
      wb = n_wr; db = n_done;
      pulse_start();
      repeat (300) tick();
      check("f2_busy_mid", int'(bus.Busy), 1);
      pulse_start();
      wait_done("f2", db);
      repeat (10) tick();
      check("f2_not_queued", int'(bus.Busy), 0);
      check("f2_writes", n_wr - wb, NBYTES);
      check("f2_done_count", n_done - db, 1);
      check_bytes("f2", wb, 'h1B, 'h1B);

      // Frame 3: sampler mute at (5,0) -> timeout, pixel forced to 00, byte 1 = 11_00_11_11.
      samp_mode = 2;
      wb = n_wr; db = n_done;
      pulse_start();
      wait_done("f3", db);
      check("f3_timeout_err", int'(bus.TimeoutErr), 1);
      check("f3_timeout_delay", te_rise_cyc - ss_to_cyc, TIMEOUT + 1);
      check("f3_writes", n_wr - wb, NBYTES);
      check_bytes("f3", wb, 'hFF, 'hCF);

      // Frame 4: timeout at (5,0), then abort at (8,2); TimeoutErr must hold.
      repeat (5) tick();
      db = n_done;
      pulse_start();
      t = 0;
      while (!(bus.PixelX == 7'd8 && bus.PixelY == 7'd2) && t < BUDGET) begin
         tick();
         t++;
      end
      check("f4_reach_abort_px", int'(t < BUDGET), 1);
      bus.FrameAbort = 1'b1;
      wb = n_wr;
      tick();
      check("f4_abort_busy", int'(bus.Busy), 0);
      check("f4_abort_ss", int'(bus.SampleStart), 0);
      check("f4_abort_te_held", int'(bus.TimeoutErr), 1);
      pulse_start();
      repeat (5) tick();
      check("f4_start_blocked", int'(bus.Busy), 0);
      repeat (250) tick();
      bus.FrameAbort = 1'b0;
      repeat (5) tick();
      check("f4_no_writes", n_wr - wb, 0);
      check("f4_no_done", n_done - db, 0);
      check("f4_idle", int'(bus.Busy), 0);

      // Frame 5: restart after abort begins at (0,0) with TimeoutErr cleared.
      samp_mode = 0;
      wb = n_wr; db = n_done;
      pulse_start();
      t = 0;
      while (bus.SampleStart !== 1'b1 && t < BUDGET) begin
         tick();
         t++;
      end
      check("f5_first_ss", int'(t < BUDGET), 1);
      check("f5_first_px", int'({bus.PixelX, bus.PixelY}), 0);
      check("f5_te_cleared", int'(bus.TimeoutErr), 0);
      wait_done("f5", db);
      check("f5_writes", n_wr - wb, NBYTES);
      check_bytes("f5", wb, 'hFF, 'hFF);

`ifdef AG32GBD_SCAN_TEST_PATTERN_EN
      // Test-pattern frame: no SampleStart; x=8..15 on rows 0..3 give 2'b01 per pixel.
      repeat (5) tick();
      wb = n_wr; db = n_done; sb = ss_total;
      bus.TestMode = 1'b1;
      pulse_start();
      wait_done("tp", db);
      bus.TestMode = 1'b0;
      check("tp_no_ss", ss_total - sb, 0);
      check("tp_writes", n_wr - wb, NBYTES);
      check("tp_byte0", int'(wr_data[wb]), 'h00);
      check("tp_byte1", int'(wr_data[wb + 1]), 'h00);
      check("tp_byte2", int'(wr_data[wb + 2]), 'h55);
      check("tp_byte3", int'(wr_data[wb + 3]), 'h55);
`endif

      // Reset mid-frame returns every output to zero at once.
      repeat (5) tick();
      pulse_start();
      repeat (100) tick();
      check("rst_mid_busy_before", int'(bus.Busy), 1);
      sys_resetn = 1'b0;
      #1;
      check("rst_mid_ctrl", int'({bus.SampleStart, bus.Busy, bus.FrameDone, bus.TimeoutErr, bus.WrEn}), 0);
      check("rst_mid_pos", int'({bus.PixelX, bus.PixelY, bus.WrAddr}), 0);
      check("rst_mid_wdata", int'(bus.WrData), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
